// File: rtl/cla_multiword_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package cla_multiword_sequencer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_multiword_sequencer_carry_lookahead.sv
// 8-bit carry-lookahead adder slice: each carry is a flat sum of generate/propagate products.
module carry_lookahead
  import cla_multiword_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              c0,
  output logic [BYTE_W-1:0] sum,
  output logic              c_1
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;
  logic              term;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    // c[i] = c0*p[0..i-1] + sum over k<i of g[k]*p[k+1..i-1]
    for (int unsigned i = 0; i <= BYTE_W; i++) begin
      term = c0;
      for (int unsigned j = 0; j < i; j++) begin
        term = term & p[j];
      end
      c[i] = term;
      for (int unsigned k = 0; k < i; k++) begin
        term = g[k];
        for (int unsigned j = k + 1; j < i; j++) begin
          term = term & p[j];
        end
        c[i] = c[i] | term;
      end
    end
    sum = p ^ c[BYTE_W-1:0];
    c_1 = c[BYTE_W];
  end

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Byte-serial multi-precision add/subtract around one shared 8-bit carry-lookahead slice.
module cla_multiword_sequencer
  import cla_multiword_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sub,
  input  logic [BYTE_W*WORDS-1:0]   a,
  input  logic [BYTE_W*WORDS-1:0]   b,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [BYTE_W*WORDS-1:0]   result,
  output logic                      cout,
  output logic                      ovf
);

  localparam int unsigned W     = BYTE_W * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);

  state_e             state_q, state_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic [W-1:0]       result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [BYTE_W-1:0]  a_byte;
  logic [BYTE_W-1:0]  b_byte;
  logic [BYTE_W-1:0]  sum_byte;
  logic               c_out;
  logic               last_byte;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = op_a_q[i*BYTE_W +: BYTE_W];
        b_byte = op_b_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  carry_lookahead u_cla (
    .a   (a_byte),
    .b   (b_byte),
    .c0  (carry_q),
    .sum (sum_byte),
    .c_1 (c_out)
  );

  assign last_byte = (idx_q == IDX_W'(WORDS - 1));
  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B once here and seed the carry with 1.
          state_d  = RUN;
          op_a_d   = a;
          op_b_d   = sub ? ~b : b;
          carry_d  = sub;
          idx_d    = '0;
          result_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[i*BYTE_W +: BYTE_W] = sum_byte;
          end
        end
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (last_byte) begin
          state_d = DONE;
          cout_d  = c_out;
          ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (sum_byte[BYTE_W-1] != op_a_q[W-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Scoreboard bench for cla_multiword_sequencer (WORDS=4): driver pushes expectations, monitor checks on done.
module tb_cla_multiword_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 8 * WORDS;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    int unsigned  done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] result;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  cyc = 0;
  exp_t         sb[$];

  cla_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: arithmetic on 33 bits, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    exp_t e;
    logic [W:0] full;
    if (ms) full = {1'b0, ma} - {1'b0, mb};
    else    full = {1'b0, ma} + {1'b0, mb};
    e.res = full[W-1:0];
    e.c   = ms ? (ma >= mb) : full[W];
    if (ms) e.o = (ma[W-1] != mb[W-1]) && (e.res[W-1] != ma[W-1]);
    else    e.o = (ma[W-1] == mb[W-1]) && (e.res[W-1] != ma[W-1]);
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    int unsigned w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      chk("ready_timeout", {{(W-1){1'b0}}, ready}, 1);
      return;
    end
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    e.res = er; e.c = ec; e.o = eo; e.done_cyc = cyc + WORDS;
    sb.push_back(e);
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, e.c});
        chk("ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, e.o});
        chk("done_cycle", W'(cyc), W'(e.done_cyc));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    logic [W-1:0] ra, rb;
    logic rs;
    int unsigned w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {{(W-1){1'b0}}, ready}, 1);
    chk("rst_busy", {{(W-1){1'b0}}, busy}, 0);
    chk("rst_done", {{(W-1){1'b0}}, done}, 0);
    chk("rst_result", result, '0);
    chk("rst_flags", {{(W-2){1'b0}}, cout, ovf}, 0);
    rst_n = 1'b1;

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Starts during busy cycles 2 and 3 must be ignored.
    do_op(32'h0102_0304, 32'h1010_1010, 1'b0, 32'h1112_1314, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1;
    @(negedge clk);
    a = 32'h5555_5555; b = 32'hAAAA_AAAA; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    do_op(32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset in the middle of a run aborts it without a done pulse.
    do_op(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 32'hBBBB_BBBB, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    void'(sb.pop_back());
    chk("abort_ready", {{(W-1){1'b0}}, ready}, 1);
    chk("abort_busy", {{(W-1){1'b0}}, busy}, 0);
    chk("abort_done", {{(W-1){1'b0}}, done}, 0);
    chk("abort_result", result, '0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_idle_result", result, '0);

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = ra;
      if (i % 11 == 0) ra = 32'h8000_0000;
      rs = 1'($urandom);
      r = model(ra, rb, rs);
      do_op(ra, rb, rs, r.res, r.c, r.o);
    end

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drain", W'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
